// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: direction counter
// encodings and PC index/tag slicing helpers.
package bpu_pkg;

    // Named encodings of the default 2-bit direction counter
    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } cnt_e;

    // Weakly-not-taken for any width: MSB clear, all lower bits set
    function automatic logic [31:0] cnt_wnt(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // Weakly-taken for any width: MSB set, all lower bits clear
    function automatic logic [31:0] cnt_wt(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Table index: word-aligned PC bits just above the byte offset
    function automatic logic [63:0] pc_idx(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Tag: every PC bit above the index
    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/bpu_sat_cnt.sv
// W-bit saturating up/down counter with enable, parallel load and a
// configurable reset value.
module bpu_sat_cnt #(
    parameter int             W       = 2,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load wins over counting; counting stops at either rail
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (up && (cnt_q != {W{1'b1}})) begin
                cnt_d = cnt_q + W'(1);
            end else if (!up && (cnt_q != '0)) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bpu_btb_bht.sv
// Branch target buffer with per-entry saturating direction counters and a
// saturating mispredict counter. Lookup is combinational on the decode PC;
// resolution updates from EX land on the next rising edge.
// Optional: define BPU_GSHARE_EN to index the direction counters with the
// PC index XORed with a non-speculative global history register.
module bpu_btb_bht
    import bpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = 2,
    parameter int GHR_W   = 8,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [XLEN-1:0]   lk_target,
    input  logic              up_valid,
    input  logic [XLEN-1:0]   up_pc,
    input  logic [XLEN-1:0]   up_target,
    input  logic              up_taken,
    input  logic              up_mispredict,
    input  logic              stall,
    input  logic              inv_all,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(cnt_wnt(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_wt(CNT_W));

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t              entry_q [ENTRIES];
    entry_t              entry_d [ENTRIES];
    logic [CNT_W-1:0]    cnt_val [ENTRIES];
    logic [ENTRIES-1:0]  cnt_en, cnt_ld;
    logic [PERF_W-1:0]   mis_q, mis_d;

    logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit, upd_acc;

    assign lk_idx = IDX_W'(pc_idx(64'(lk_pc), IDX_W));
    assign up_idx = IDX_W'(pc_idx(64'(up_pc), IDX_W));
    assign lk_tag = TAG_W'(pc_tag(64'(lk_pc), IDX_W));
    assign up_tag = TAG_W'(pc_tag(64'(up_pc), IDX_W));

    // inv_all takes priority: a flush cycle never trains the tables
    assign upd_acc = up_valid & ~stall & ~inv_all;
    assign up_hit  = entry_q[up_idx].valid && (entry_q[up_idx].tag == up_tag);

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // History shifts only on resolved, accepted updates
    always_comb begin
        ghr_d = upd_acc ? {ghr_q[GHR_W-2:0], up_taken} : ghr_q;
    end

    // Global history register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign lk_cidx = lk_idx ^ ghr_q[IDX_W-1:0];
    assign up_cidx = up_idx ^ ghr_q[IDX_W-1:0];
`else
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    // Lookup reflects pre-edge state; no bypass of a same-cycle update
    always_comb begin
        lk_hit    = entry_q[lk_idx].valid && (entry_q[lk_idx].tag == lk_tag);
        lk_taken  = lk_hit && cnt_val[lk_cidx][CNT_W-1];
        lk_target = lk_hit ? entry_q[lk_idx].target : '0;
    end

    // Taken outcome refreshes a hit's target or allocates on a miss; same write
    always_comb begin
        entry_d = entry_q;
        if (inv_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else if (upd_acc && up_taken) begin
            entry_d[up_idx].valid  = 1'b1;
            entry_d[up_idx].tag    = up_tag;
            entry_d[up_idx].target = up_target;
        end
    end

    // BTB entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    // Hits train the counter; taken misses seed it at weakly-taken
    always_comb begin
        cnt_en = '0;
        cnt_ld = '0;
        if (upd_acc) begin
            if (up_hit) begin
                cnt_en[up_cidx] = 1'b1;
            end else if (up_taken) begin
                cnt_ld[up_cidx] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
        bpu_sat_cnt #(
            .W       (CNT_W),
            .RST_VAL (CNT_RST)
        ) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (cnt_en[g]),
            .up       (up_taken),
            .load     (cnt_ld[g]),
            .load_val (CNT_ALLOC),
            .cnt      (cnt_val[g])
        );
    end

    // Mispredict count ignores inv_all but respects stall; sticks at max
    always_comb begin
        mis_d = mis_q;
        if (up_valid && up_mispredict && !stall && (mis_q != {PERF_W{1'b1}})) begin
            mis_d = mis_q + PERF_W'(1);
        end
    end

    // Mispredict counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= '0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign mispred_cnt = mis_q;

endmodule

// File: tb/tb_bpu_btb_bht.sv
// Self-checking bench for bpu_btb_bht (default bimodal build, 16 entries,
// 2-bit counters): directed scenarios plus randomized traffic against a
// behavioural table model.
module tb_bpu_btb_bht;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lk_pc;
    logic        lk_hit, lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic [31:0] up_pc, up_target;
    logic        up_taken, up_mispredict, stall, inv_all;
    logic [15:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: plain arrays indexed by pc[5:2], counter as 0..3
    bit          m_val [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_cnt [16];
    int          m_mis;

    bpu_btb_bht dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_pc         (lk_pc),
        .lk_hit        (lk_hit),
        .lk_taken      (lk_taken),
        .lk_target     (lk_target),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_target     (up_target),
        .up_taken      (up_taken),
        .up_mispredict (up_mispredict),
        .stall         (stall),
        .inv_all       (inv_all),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_val[k] = 1'b0;
            m_cnt[k] = 1;
        end
        m_mis = 0;
    endtask

    task automatic model_check();
        int  i;
        bit  h;
        i = int'(lk_pc[5:2]);
        h = m_val[i] && (m_tag[i] == lk_pc[31:6]);
        chk("lk_hit", {31'd0, lk_hit}, {31'd0, h});
        chk("lk_taken", {31'd0, lk_taken}, {31'd0, h && (m_cnt[i] >= 2)});
        chk("lk_target", lk_target, h ? m_tgt[i] : 32'd0);
        chk("mispred_cnt", {16'd0, mispred_cnt}, m_mis);
    endtask

    task automatic model_update();
        int i;
        bit h;
        if (up_valid && up_mispredict && !stall && m_mis < 65535) m_mis++;
        if (inv_all) begin
            for (int k = 0; k < 16; k++) m_val[k] = 1'b0;
        end else if (up_valid && !stall) begin
            i = int'(up_pc[5:2]);
            h = m_val[i] && (m_tag[i] == up_pc[31:6]);
            if (h) begin
                if (up_taken) begin
                    m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    m_tgt[i] = up_target;
                end else begin
                    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                end
            end else if (up_taken) begin
                m_val[i] = 1'b1;
                m_tag[i] = up_pc[31:6];
                m_tgt[i] = up_target;
                m_cnt[i] = 2;
            end
        end
    endtask

    // Called just after a falling edge: drive, settle, compare pre-edge outputs
    task automatic drive(input logic [31:0] lk, input bit uv, input logic [31:0] upc,
                         input logic [31:0] ut, input bit tk, input bit mp,
                         input bit st, input bit inv);
        lk_pc         = lk;
        up_valid      = uv;
        up_pc         = upc;
        up_target     = ut;
        up_taken      = tk;
        up_mispredict = mp;
        stall         = st;
        inv_all       = inv;
        #1;
        model_check();
    endtask

    task automatic look(input logic [31:0] lk);
        drive(lk, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] t, i, o;
        t = $urandom_range(4, 7);
        i = $urandom_range(0, 15);
        o = $urandom_range(0, 3);
        return (t << 6) | (i << 2) | o;
    endfunction

    initial begin
        logic [31:0] upc, lk;
        bit          uv, tk, mp, st, inv;

        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        look(32'h100);
        chk("reset_hit", {31'd0, lk_hit}, 32'd0);
        chk("reset_taken", {31'd0, lk_taken}, 32'd0);
        chk("reset_target", lk_target, 32'd0);
        chk("reset_mispred", {16'd0, mispred_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Allocate, then weaken below taken threshold
        drive(32'h100, 1, 32'h100, 32'h180, 1, 0, 0, 0); tick();
        look(32'h100);
        chk("alloc_hit", {31'd0, lk_hit}, 32'd1);
        chk("alloc_taken", {31'd0, lk_taken}, 32'd1);
        chk("alloc_target", lk_target, 32'h180);
        drive(32'h100, 1, 32'h100, 32'h999, 0, 0, 0, 0); tick();
        drive(32'h100, 1, 32'h100, 32'h999, 0, 0, 0, 0); tick();
        look(32'h100);
        chk("weak_taken", {31'd0, lk_taken}, 32'd0);
        chk("weak_hit", {31'd0, lk_hit}, 32'd1);
        chk("weak_target", lk_target, 32'h180);

        // Saturate at strongly taken, then one not-taken stays taken
        for (int n = 0; n < 4; n++) begin
            drive(32'h104, 1, 32'h104, 32'h200, 1, 0, 0, 0); tick();
        end
        drive(32'h104, 1, 32'h104, 32'h200, 0, 0, 0, 0); tick();
        look(32'h104);
        chk("sat_taken", {31'd0, lk_taken}, 32'd1);

        // Same index, new tag replaces the entry
        drive(32'h140, 1, 32'h140, 32'h300, 1, 0, 0, 0); tick();
        look(32'h100);
        chk("replace_old_hit", {31'd0, lk_hit}, 32'd0);
        look(32'h140);
        chk("replace_new_hit", {31'd0, lk_hit}, 32'd1);
        chk("replace_new_target", lk_target, 32'h300);

        // Stall freezes everything
        drive(32'h200, 1, 32'h200, 32'h400, 1, 1, 1, 0); tick();
        look(32'h200);
        chk("stall_no_alloc", {31'd0, lk_hit}, 32'd0);
        chk("stall_mispred", {16'd0, mispred_cnt}, 32'd0);
        look(32'h140);
        chk("stall_keep", {31'd0, lk_hit}, 32'd1);

        // inv_all clears valids but still counts the mispredict
        drive(32'h140, 1, 32'h208, 32'h400, 1, 1, 0, 1); tick();
        look(32'h140);
        chk("inv_miss_a", {31'd0, lk_hit}, 32'd0);
        look(32'h104);
        chk("inv_miss_b", {31'd0, lk_hit}, 32'd0);
        look(32'h208);
        chk("inv_no_alloc", {31'd0, lk_hit}, 32'd0);
        chk("inv_mispred", {16'd0, mispred_cnt}, 32'd1);

        // Randomized traffic, with an asynchronous reset in the middle
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                #2;
                rst_n = 1'b0;
                #1;
                chk("midrst_hit", {31'd0, lk_hit}, 32'd0);
                chk("midrst_target", lk_target, 32'd0);
                chk("midrst_mispred", {16'd0, mispred_cnt}, 32'd0);
                model_reset();
                @(negedge clk);
                drive(32'h100, 1, 32'h100, 32'h500, 1, 1, 0, 0);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                look(32'h100);
            end
            upc = rpc();
            lk  = ($urandom_range(0, 1) == 1) ? upc : rpc();
            uv  = ($urandom_range(0, 9) < 6);
            tk  = ($urandom_range(0, 1) == 1);
            mp  = ($urandom_range(0, 4) == 0);
            st  = ($urandom_range(0, 6) == 0);
            inv = !st && ($urandom_range(0, 49) == 0);
            drive(lk, uv, upc, $urandom(), tk, mp, st, inv);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
